// File: rtl/clk_sync_pkg.sv
// Shared constants for the multi-channel event synchroniser.
package clk_sync_pkg;

    // Event definitions selectable through the MODE parameter
    localparam int CS_MODE_TOGGLE = 0;
    localparam int CS_MODE_RISE   = 1;
    localparam int CS_MODE_FALL   = 2;

    // Legal range of synchroniser depth
    localparam int CS_STAGES_MIN  = 2;
    localparam int CS_STAGES_MAX  = 4;

endpackage

// File: rtl/clk_sync_chan.sv
// One channel: synchroniser chain, history flop, edge detector,
// saturating pending counter and sticky overflow flag.
module clk_sync_chan
    import clk_sync_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int MODE   = 0,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed,
    input  logic             sig,
    input  logic             ready,
    input  logic             ovf_clr,
    output logic             pulse,
    output logic             valid,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;
    logic             hist;
    logic             s_last;
    logic             raw;
    logic             inc;
    logic             dec;
    logic             sat_hit;
    logic [CNT_W-1:0] cnt;

    assign s_last = sync[STAGES-1];

    // Synchroniser chain and one-cycle history of its last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], sig};
            hist <= s_last;
        end
    end

    // Edge detection from registered values only
    always_comb begin
        raw = 1'b0;
        if (MODE == CS_MODE_TOGGLE) begin
            raw = s_last ^ hist;
        end else if (MODE == CS_MODE_RISE) begin
            raw = s_last & ~hist;
        end else if (MODE == CS_MODE_FALL) begin
            raw = ~s_last & hist;
        end
    end

    assign pulse   = raw & armed;
    assign valid   = (cnt != '0);
    assign pend    = cnt;
    assign inc     = pulse;
    assign dec     = valid & ready;
    assign sat_hit = inc & ~dec & (cnt == CNT_MAX);

    // Pending counter: simultaneous strobe and accept cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky overflow: a lost event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (sat_hit) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_sync_multi.sv
// Multi-channel event synchroniser into the clk domain with a shared
// post-reset arming counter and per-channel valid/ready drain.
module clk_sync_multi
    import clk_sync_pkg::*;
#(
    parameter int CH     = 4,
    parameter int STAGES = 2,
    parameter int MODE   = 0,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       async_i,
    output logic [CH-1:0]       pulse_o,
    output logic [CH-1:0]       valid_o,
    input  logic [CH-1:0]       ready_i,
    output logic [CH*CNT_W-1:0] pend_o,
    output logic [CH-1:0]       ovf_o,
    input  logic [CH-1:0]       ovf_clr_i
);

    localparam int PRIME_N = STAGES + 1;
    localparam int PRIME_W = $clog2(PRIME_N + 1);

    logic [PRIME_W-1:0] prime_cnt;
    logic               armed;

    if (STAGES < CS_STAGES_MIN || STAGES > CS_STAGES_MAX) begin : g_bad_stages
        $error("clk_sync_multi: STAGES out of range");
    end
    if (MODE < CS_MODE_TOGGLE || MODE > CS_MODE_FALL) begin : g_bad_mode
        $error("clk_sync_multi: unknown MODE");
    end

    // Holds events off until the chains and history flops hold real samples
    assign armed = (prime_cnt == PRIME_W'(PRIME_N));

    // Prime counter: runs STAGES+1 cycles after reset release, then parks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (!armed) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    for (genvar n = 0; n < CH; n++) begin : g_chan
        clk_sync_chan #(
            .STAGES (STAGES),
            .MODE   (MODE),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .armed   (armed),
            .sig     (async_i[n]),
            .ready   (ready_i[n]),
            .ovf_clr (ovf_clr_i[n]),
            .pulse   (pulse_o[n]),
            .valid   (valid_o[n]),
            .pend    (pend_o[n*CNT_W +: CNT_W]),
            .ovf     (ovf_o[n])
        );
    end

endmodule

// File: tb/tb_clk_sync_multi.sv
// Directed self-checking bench: a MODE 0 instance and a MODE 1 instance
// share clock and reset; expected values are hand-derived per step.
module tb_clk_sync_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  async0, ready0, clr0, pulse0, valid0, ovf0;
    logic [15:0] pend0;
    logic [3:0]  async1, ready1, clr1, pulse1, valid1, ovf1;
    logic [15:0] pend1;

    int checks = 0;
    int errors = 0;

    clk_sync_multi #(.CH(4), .STAGES(2), .MODE(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .async_i(async0), .pulse_o(pulse0),
        .valid_o(valid0), .ready_i(ready0), .pend_o(pend0),
        .ovf_o(ovf0), .ovf_clr_i(clr0)
    );

    clk_sync_multi #(.CH(4), .STAGES(2), .MODE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .async_i(async1), .pulse_o(pulse1),
        .valid_o(valid1), .ready_i(ready1), .pend_o(pend1),
        .ovf_o(ovf1), .ovf_clr_i(clr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    initial begin
        rst    = 1'b1;
        async0 = 4'b0000; ready0 = 4'b0000; clr0 = 4'b0000;
        async1 = 4'b0001; ready1 = 4'b0000; clr1 = 4'b0000;
        tick();
        tick();
        chk("rst_pulse0", pulse0, 4'h0);
        chk("rst_valid0", valid0, 4'h0);
        chk("rst_pend0",  pend0,  16'h0);
        chk("rst_ovf0",   ovf0,   4'h0);
        chk("rst_pend1",  pend1,  16'h0);
        rst = 1'b0;

        // MODE 1 level held high through reset: never an event
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("m1_hold_pulse", pulse1, 4'h0);
            chk("m1_hold_pend",  pend1,  16'h0);
        end
        async1[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("m1_fall_pulse", pulse1, 4'h0);
        end
        async1[0] = 1'b1;
        tick(); chk("m1_rise_e1", pulse1, 4'h0);
        tick(); chk("m1_rise_e2", pulse1, 4'h1);
        tick(); chk("m1_rise_e3", pulse1, 4'h0);
        chk("m1_rise_pend",  pend1,  16'h0001);
        chk("m1_rise_valid", valid1, 4'h1);

        // MODE 0 latency on channel 1
        async0[1] = 1'b1;
        tick(); chk("lat_k",       pulse0, 4'h0);
        tick(); chk("lat_k1",      pulse0, 4'h2);
        chk("lat_k1_valid", valid0, 4'h0);
        tick(); chk("lat_k2",      pulse0, 4'h0);
        chk("lat_k2_valid", valid0, 4'h2);
        chk("lat_k2_pend",  pend0,  16'h0010);
        ready0[1] = 1'b1;
        tick(); chk("lat_drain",   pend0,  16'h0);
        chk("lat_drain_valid", valid0, 4'h0);
        tick(); chk("no_underflow", pend0, 16'h0);
        ready0[1] = 1'b0;

        // Three events on channel 2, then drain with ready held high
        for (int e = 0; e < 3; e++) begin
            async0[2] = ~async0[2];
            repeat (4) tick();
        end
        chk("acc3_pend",  pend0,  16'h0300);
        chk("acc3_valid", valid0, 4'h4);
        ready0[2] = 1'b1;
        tick(); chk("drain_a", pend0, 16'h0200); chk("drain_a_v", valid0, 4'h4);
        tick(); chk("drain_b", pend0, 16'h0100); chk("drain_b_v", valid0, 4'h4);
        tick(); chk("drain_c", pend0, 16'h0000); chk("drain_c_v", valid0, 4'h0);
        tick(); chk("drain_d", pend0, 16'h0000);
        ready0[2] = 1'b0;

        // Strobe coinciding with an accept at pend 2 holds the count
        for (int e = 0; e < 2; e++) begin
            async0[2] = ~async0[2];
            repeat (4) tick();
        end
        chk("coin_pre", pend0, 16'h0200);
        async0[2] = ~async0[2];
        tick();
        tick(); chk("coin_pulse", pulse0, 4'h4);
        ready0[2] = 1'b1;
        tick(); chk("coin_hold", pend0, 16'h0200);
        chk("coin_pulse_end", pulse0, 4'h0);
        ready0[2] = 1'b0;
        tick(); chk("coin_after", pend0, 16'h0200);

        // Saturation and sticky overflow on channel 3
        for (int i = 0; i < 16; i++) begin
            async0[3] = ~async0[3];
            repeat (4) tick();
            if (i == 14) begin
                chk("sat_15_pend", pend0[15:12], 4'hF);
                chk("sat_15_ovf",  ovf0, 4'h0);
            end
        end
        chk("sat_pend", pend0, 16'hF200);
        chk("sat_ovf",  ovf0,  4'h8);
        clr0[3] = 1'b1;
        tick();
        clr0[3] = 1'b0;
        chk("ovf_clr",      ovf0,  4'h0);
        chk("ovf_clr_pend", pend0, 16'hF200);
        async0[3] = ~async0[3];
        tick();
        tick(); chk("setclr_pulse", pulse0, 4'h8);
        clr0[3] = 1'b1;
        tick();
        clr0[3] = 1'b0;
        chk("setclr_ovf",  ovf0,  4'h8);
        chk("setclr_pend", pend0, 16'hF200);
        tick(); chk("ovf_sticky", ovf0, 4'h8);

        // Reset mid-drain with channel 2 at pend 5
        for (int e = 0; e < 3; e++) begin
            async0[2] = ~async0[2];
            repeat (4) tick();
        end
        chk("pre_rst_pend", pend0, 16'hF500);
        ready0[2] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pend0",  pend0,  16'h0);
        chk("arst_valid0", valid0, 4'h0);
        chk("arst_ovf0",   ovf0,   4'h0);
        chk("arst_pulse0", pulse0, 4'h0);
        chk("arst_pend1",  pend1,  16'h0);
        chk("arst_valid1", valid1, 4'h0);
        ready0 = 4'b0000;
        async0 = 4'b0001;
        tick();
        rst = 1'b0;
        tick(); chk("rearm_e1", pulse0, 4'h0);
        async0[1] = 1'b1;
        tick(); chk("rearm_e2", pulse0, 4'h0);
        chk("rearm_e2_m1", pulse1, 4'h0);
        tick(); chk("rearm_e3", pulse0, 4'h2);
        chk("rearm_e3_pend", pend0, 16'h0);
        chk("rearm_e3_m1",   pulse1, 4'h0);
        tick(); chk("rearm_e4", pulse0, 4'h0);
        chk("rearm_e4_pend", pend0, 16'h0010);
        tick(); chk("rearm_e5_pend", pend0, 16'h0010);
        chk("rearm_e5_pend1", pend1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
